// File: rtl/md_pkg.sv
// Shared multiply/divide definitions. The decoder, the stall unit and md_unit all use
// these Op encodings and default latencies.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam int MD_MUL_CYCLES = 5;
  localparam int MD_DIV_CYCLES = 10;

  // Ops that occupy the unit for several cycles (MULT/MULTU/DIV/DIVU).
  function automatic logic md_is_multi(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_if.sv
// EX-stage issue bus into the multiply/divide unit.
// Handshake: Start is sampled on posedge Clk and accepted only while Busy is low and Cancel is low;
// the issuer must hold the instruction itself while Busy is high, since a Start seen then is dropped.
interface md_if;
  import md_pkg::*;

  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cancel;
  logic        Busy;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic [0:0]  dbg_state;

  modport master (
    output Start, Op, A, B, Cancel,
    input  Busy, Hi, Lo, dbg_state
  );

  modport slave (
    input  Start, Op, A, B, Cancel,
    output Busy, Hi, Lo, dbg_state
  );

endinterface

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath: 64-bit {hi,lo} result for the selected op,
// plus a divide-by-zero flag so the caller can leave HI/LO untouched.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [63:0] a_sx, b_sx, a_zx, b_zx;
  logic [31:0] a_mag, b_mag, b_safe, bmag_safe;
  logic [31:0] uq, ur, sq, sr;
  logic [31:0] sq_fix, sr_fix;

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    a_sx      = {{32{a[31]}}, a};
    b_sx      = {{32{b[31]}}, b};
    a_zx      = {32'd0, a};
    b_zx      = {32'd0, b};
    a_mag     = a[31] ? (32'd0 - a) : a;
    b_mag     = b[31] ? (32'd0 - b) : b;
    b_safe    = (b == 32'd0) ? 32'd1 : b;
    bmag_safe = (b == 32'd0) ? 32'd1 : b_mag;
    uq        = a / b_safe;
    ur        = a % b_safe;
    sq        = a_mag / bmag_safe;
    sr        = a_mag % bmag_safe;
    sq_fix    = (a[31] ^ b[31]) ? (32'd0 - sq) : sq;
    sr_fix    = a[31] ? (32'd0 - sr) : sr;

    result = 64'd0;
    case (op)
      MD_MULT:  result = a_sx * b_sx;
      MD_MULTU: result = a_zx * b_zx;
      MD_DIV:   result = {sr_fix, sq_fix};
      MD_DIVU:  result = {ur, uq};
      default:  result = 64'd0;
    endcase

    div_by_zero = md_is_div(op) && (b == 32'd0);
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, runs MULT/DIV as fixed-latency ops with Busy,
// and performs MTHI/MTLO in one cycle. Priority is Rst > Cancel > completion/Start.
module md_unit
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = MD_MUL_CYCLES,
  parameter int DIV_CYCLES = MD_DIV_CYCLES
) (
  input logic Clk,
  input logic Rst,
  md_if.slave bus
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [CW-1:0] cnt;
  logic          busy;
  logic [63:0]   pend;
  logic          pend_wr;
  logic [31:0]   hi, lo;
  logic [63:0]   calc_res;
  logic          calc_dbz;

  md_calc u_calc (
    .op          (bus.Op),
    .a           (bus.A),
    .b           (bus.B),
    .result      (calc_res),
    .div_by_zero (calc_dbz)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt     <= '0;
      busy    <= 1'b0;
      pend    <= 64'd0;
      pend_wr <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else if (bus.Cancel) begin
      cnt     <= '0;
      busy    <= 1'b0;
      pend    <= 64'd0;
      pend_wr <= 1'b0;
    end else if (cnt != '0) begin
      cnt  <= cnt - 1'b1;
      busy <= (cnt != CW'(1));
      // Final edge of the op: publish the result unless it was a divide by zero.
      if (cnt == CW'(1) && pend_wr) begin
        hi <= pend[63:32];
        lo <= pend[31:0];
      end
    end else if (bus.Start) begin
      if (md_is_multi(bus.Op)) begin
        pend    <= calc_res;
        pend_wr <= !calc_dbz;
        cnt     <= md_is_div(bus.Op) ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        busy    <= 1'b1;
      end else if (bus.Op == MD_MTHI) begin
        hi <= bus.A;
      end else if (bus.Op == MD_MTLO) begin
        lo <= bus.A;
      end
    end
  end

  assign bus.Busy      = busy;
  assign bus.Hi        = hi;
  assign bus.Lo        = lo;
  assign bus.dbg_state = busy ? ST_RUN : ST_IDLE;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, arithmetic results, MT ops, Cancel and Rst behaviour.
module tb_md_unit;
  import md_pkg::*;

  logic Clk;
  logic Rst;
  int   checks;
  int   failures;
  bit   allow_busy_start;

  md_if bus ();

  md_unit dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Issuing while Busy is a stall-unit bug, except where a test does it on purpose.
  always @(posedge Clk) begin
    if (Rst === 1'b0 && bus.Start === 1'b1 && bus.Busy === 1'b1 && !allow_busy_start) begin
      failures++;
      $display("FAIL start_while_busy: Start=1 seen with Busy=%b at %0t", bus.Busy, $time);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.Start = 1'b0;
  endtask

  // Counts remaining Busy cycles (bounded) and notes whether Hi/Lo moved while busy.
  task automatic run_busy(input logic [31:0] old_hi, input logic [31:0] old_lo,
                          output int cycles, output bit stable);
    cycles = 0;
    stable = 1'b1;
    while (bus.Busy === 1'b1 && cycles < 100) begin
      cycles++;
      if (bus.Hi !== old_hi || bus.Lo !== old_lo) stable = 1'b0;
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) tick();
    Rst = 1'b0;
    checks++; if (bus.Hi !== 32'd0) begin failures++; $display("FAIL reset_hi: got %h expected %h", bus.Hi, 32'd0); end
    checks++; if (bus.Lo !== 32'd0) begin failures++; $display("FAIL reset_lo: got %h expected %h", bus.Lo, 32'd0); end
    checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
    checks++; if (bus.dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state: got %b expected 0", bus.dbg_state); end
  endtask

  task automatic test_mult();
    int cyc; bit st;
    issue(MD_MULT, 32'hFFFFFFFF, 32'd2);
    run_busy(32'd0, 32'd0, cyc, st);
    checks++; if (cyc !== 5) begin failures++; $display("FAIL mult_busy_cycles: got %0d expected 5", cyc); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL mult_hilo_mid_op: got changed expected stable"); end
    checks++; if (bus.Hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi: got %h expected %h", bus.Hi, 32'hFFFFFFFF); end
    checks++; if (bus.Lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL mult_lo: got %h expected %h", bus.Lo, 32'hFFFFFFFE); end
    issue(MD_MULTU, 32'hFFFFFFFF, 32'd2);
    run_busy(32'hFFFFFFFF, 32'hFFFFFFFE, cyc, st);
    checks++; if (cyc !== 5) begin failures++; $display("FAIL multu_busy_cycles: got %0d expected 5", cyc); end
    checks++; if (bus.Hi !== 32'h00000001) begin failures++; $display("FAIL multu_hi: got %h expected %h", bus.Hi, 32'h1); end
    checks++; if (bus.Lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_lo: got %h expected %h", bus.Lo, 32'hFFFFFFFE); end
  endtask

  task automatic test_div();
    int cyc; bit st;
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    run_busy(32'h00000001, 32'hFFFFFFFE, cyc, st);
    checks++; if (cyc !== 10) begin failures++; $display("FAIL div_busy_cycles: got %0d expected 10", cyc); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL div_hilo_mid_op: got changed expected stable"); end
    checks++; if (bus.Lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo: got %h expected %h", bus.Lo, 32'hFFFFFFFD); end
    checks++; if (bus.Hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi: got %h expected %h", bus.Hi, 32'hFFFFFFFF); end
    issue(MD_DIVU, 32'd7, 32'd2);
    run_busy(32'hFFFFFFFF, 32'hFFFFFFFD, cyc, st);
    checks++; if (bus.Lo !== 32'd3) begin failures++; $display("FAIL divu_lo: got %h expected %h", bus.Lo, 32'd3); end
    checks++; if (bus.Hi !== 32'd1) begin failures++; $display("FAIL divu_hi: got %h expected %h", bus.Hi, 32'd1); end
  endtask

  task automatic test_div_edge();
    int cyc; bit st;
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    run_busy(32'd1, 32'd3, cyc, st);
    checks++; if (bus.Lo !== 32'h80000000) begin failures++; $display("FAIL div_ovf_lo: got %h expected %h", bus.Lo, 32'h80000000); end
    checks++; if (bus.Hi !== 32'd0) begin failures++; $display("FAIL div_ovf_hi: got %h expected %h", bus.Hi, 32'd0); end
    issue(MD_MTHI, 32'h11, 32'd0);
    issue(MD_MTLO, 32'h22, 32'd0);
    issue(MD_DIVU, 32'd99, 32'd0);
    run_busy(32'h11, 32'h22, cyc, st);
    checks++; if (cyc !== 10) begin failures++; $display("FAIL divzero_busy_cycles: got %0d expected 10", cyc); end
    checks++; if (bus.Hi !== 32'h11) begin failures++; $display("FAIL divzero_hi: got %h expected %h", bus.Hi, 32'h11); end
    checks++; if (bus.Lo !== 32'h22) begin failures++; $display("FAIL divzero_lo: got %h expected %h", bus.Lo, 32'h22); end
  endtask

  task automatic test_mt();
    int cyc; bit st;
    issue(3'd6, 32'hDEADBEEF, 32'd5);
    checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reserved_busy: got %b expected 0", bus.Busy); end
    checks++; if (bus.Hi !== 32'h11 || bus.Lo !== 32'h22) begin failures++; $display("FAIL reserved_hilo: got %h/%h expected %h/%h", bus.Hi, bus.Lo, 32'h11, 32'h22); end
    issue(MD_MTHI, 32'h12345678, 32'd0);
    checks++; if (bus.Hi !== 32'h12345678) begin failures++; $display("FAIL mthi_hi: got %h expected %h", bus.Hi, 32'h12345678); end
    checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL mthi_busy: got %b expected 0", bus.Busy); end
    // MTLO arrives while a MULT is in flight and must be dropped.
    issue(MD_MULT, 32'd3, 32'd4);
    allow_busy_start = 1'b1;
    issue(MD_MTLO, 32'hCAFEBABE, 32'd0);
    allow_busy_start = 1'b0;
    checks++; if (bus.Lo !== 32'h22) begin failures++; $display("FAIL mtlo_busy_lo: got %h expected %h", bus.Lo, 32'h22); end
    checks++; if (bus.Busy !== 1'b1) begin failures++; $display("FAIL mtlo_busy_flag: got %b expected 1", bus.Busy); end
    run_busy(32'h12345678, 32'h22, cyc, st);
    checks++; if (cyc !== 4) begin failures++; $display("FAIL mtlo_busy_remaining: got %0d expected 4", cyc); end
    checks++; if (bus.Lo !== 32'd12 || bus.Hi !== 32'd0) begin failures++; $display("FAIL mtlo_busy_result: got %h/%h expected %h/%h", bus.Hi, bus.Lo, 32'd0, 32'd12); end
  endtask

  task automatic test_cancel();
    issue(MD_MULT, 32'd5, 32'd5);
    repeat (2) tick();
    bus.Cancel = 1'b1;
    tick();
    bus.Cancel = 1'b0;
    checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL cancel_busy: got %b expected 0", bus.Busy); end
    repeat (6) tick();
    checks++; if (bus.Hi !== 32'd0 || bus.Lo !== 32'd12) begin failures++; $display("FAIL cancel_hilo: got %h/%h expected %h/%h", bus.Hi, bus.Lo, 32'd0, 32'd12); end
    bus.Cancel = 1'b1;
    issue(MD_MULT, 32'd7, 32'd7);
    bus.Cancel = 1'b0;
    checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL cancel_start_busy: got %b expected 0", bus.Busy); end
    repeat (6) tick();
    checks++; if (bus.Hi !== 32'd0 || bus.Lo !== 32'd12) begin failures++; $display("FAIL cancel_start_hilo: got %h/%h expected %h/%h", bus.Hi, bus.Lo, 32'd0, 32'd12); end
  endtask

  task automatic test_rst_mid_op();
    int cyc; bit st;
    issue(MD_MTHI, 32'hAAAA5555, 32'd0);
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (3) tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    checks++; if (bus.Hi !== 32'd0 || bus.Lo !== 32'd0) begin failures++; $display("FAIL rst_mid_hilo: got %h/%h expected 0/0", bus.Hi, bus.Lo); end
    checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", bus.Busy); end
    repeat (12) tick();
    checks++; if (bus.Hi !== 32'd0 || bus.Lo !== 32'd0) begin failures++; $display("FAIL rst_mid_no_late_write: got %h/%h expected 0/0", bus.Hi, bus.Lo); end
    issue(MD_MULT, 32'd3, 32'd4);
    run_busy(32'd0, 32'd0, cyc, st);
    checks++; if (cyc !== 5) begin failures++; $display("FAIL post_rst_busy_cycles: got %0d expected 5", cyc); end
    checks++; if (bus.Lo !== 32'd12 || bus.Hi !== 32'd0) begin failures++; $display("FAIL post_rst_mult: got %h/%h expected %h/%h", bus.Hi, bus.Lo, 32'd0, 32'd12); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks           = 0;
    failures         = 0;
    allow_busy_start = 1'b0;
    Rst        = 1'b1;
    bus.Start  = 1'b0;
    bus.Op     = 3'd0;
    bus.A      = 32'd0;
    bus.B      = 32'd0;
    bus.Cancel = 1'b0;

    test_reset();
    test_mult();
    test_div();
    test_div_edge();
    test_mt();
    test_cancel();
    test_rst_mid_op();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
